// File: rtl/tensor_core_pkg.sv
// tensor_core_pkg
// Shared definitions for the 4x4 byte-matrix multiply controller:
// matrix geometry, flattened matrix width, controller FSM states and the
// counter/index types used by the controller and the multiply core.
// No ports (package).
package tensor_core_pkg;

  localparam int MAT_DIM   = 4;
  localparam int ELEM_W    = 8;
  localparam int MAT_ELEMS = MAT_DIM * MAT_DIM;
  localparam int MAT_BITS  = MAT_ELEMS * ELEM_W;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN
  } state_t;

  // Operand byte index: 0..15 address A, 16..31 address B.
  typedef logic [4:0] load_idx_t;
  // Element index within one 4x4 matrix, row-major.
  typedef logic [3:0] elem_idx_t;
  // Cycle counter for the COMPUTE phase (up to 15 cycles).
  typedef logic [3:0] cycle_cnt_t;
  typedef logic [ELEM_W-1:0] elem_t;

  localparam load_idx_t LOAD_LAST = 5'd31;
  localparam elem_idx_t ELEM_LAST = 4'd15;

endpackage

// File: rtl/tensor_core.sv
// tensor_core
// Purely combinational 4x4 matrix multiply, C = A x B, with every element
// an unsigned byte and every result truncated to 8 bits (mod 256).
// Matrices are flattened row-major: element e = row*4 + col lives at
// bits [e*8 +: 8].
// Ports:
//   a_mat  in   flattened A operand
//   b_mat  in   flattened B operand
//   c_mat  out  flattened product
module tensor_core
  import tensor_core_pkg::*;
(
  input  logic [MAT_BITS-1:0] a_mat,
  input  logic [MAT_BITS-1:0] b_mat,
  output logic [MAT_BITS-1:0] c_mat
);

  elem_t acc;

  // The accumulator is only 8 bits wide on purpose: dropping the carries
  // at every step gives the same result as a full sum taken mod 256.
  always_comb begin
    c_mat = '0;
    acc   = '0;
    for (int i = 0; i < MAT_DIM; i++) begin
      for (int j = 0; j < MAT_DIM; j++) begin
        acc = '0;
        for (int k = 0; k < MAT_DIM; k++) begin
          acc = acc + elem_t'(a_mat[(i*MAT_DIM+k)*ELEM_W +: ELEM_W] *
                              b_mat[(k*MAT_DIM+j)*ELEM_W +: ELEM_W]);
        end
        c_mat[(i*MAT_DIM+j)*ELEM_W +: ELEM_W] = acc;
      end
    end
  end

endmodule

// File: rtl/tensor_core_controller.sv
// tensor_core_controller
// Streams 32 operand bytes in (A then B, both row-major), waits
// COMPUTE_CYCLES cycles, captures C = A x B, then streams the 16 result
// bytes out row-major with a valid/ready handshake.
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   clear                synchronous abort back to LOAD, counters zeroed
//   in_valid/in_ready    operand byte handshake, in_data is the byte
//   out_valid/out_ready  result byte handshake, out_data is the byte
//   busy                 high while computing or draining
//   done                 one-cycle pulse after the final result byte is taken
module tensor_core_controller
  import tensor_core_pkg::*;
#(
  parameter int unsigned COMPUTE_CYCLES = 1
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       done
);

  localparam cycle_cnt_t COMP_LAST = cycle_cnt_t'(COMPUTE_CYCLES - 1);

  state_t              state_q, state_d;
  load_idx_t           load_cnt_q, load_cnt_d;
  elem_idx_t           drain_cnt_q, drain_cnt_d;
  cycle_cnt_t          comp_cnt_q, comp_cnt_d;
  logic [MAT_BITS-1:0] a_q, a_d;
  logic [MAT_BITS-1:0] b_q, b_d;
  logic [MAT_BITS-1:0] c_q, c_d;
  logic [MAT_BITS-1:0] c_mat;
  logic                done_q, done_d;

  // The multiplier sees the operand registers directly; they only change
  // during LOAD, so the product is settled well before it is captured.
  tensor_core u_core (
    .a_mat (a_q),
    .b_mat (b_q),
    .c_mat (c_mat)
  );

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_DRAIN);
  assign busy      = (state_q != ST_LOAD);
  // Result byte selection is purely from registered state, so the byte
  // cannot move while the consumer stalls.
  assign out_data  = c_q[drain_cnt_q*ELEM_W +: ELEM_W];
  assign done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      load_cnt_q  <= '0;
      drain_cnt_q <= '0;
      comp_cnt_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      comp_cnt_q  <= comp_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic. clear is checked first so it wins over any handshake
  // happening in the same cycle and never produces a done pulse.
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    drain_cnt_d = drain_cnt_q;
    comp_cnt_d  = comp_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    done_d      = 1'b0;

    if (clear) begin
      state_d     = ST_LOAD;
      load_cnt_d  = '0;
      drain_cnt_d = '0;
      comp_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_valid) begin
            // Bit 4 of the byte index selects A or B; the low bits are the
            // row-major element position.
            if (load_cnt_q[4]) begin
              b_d[load_cnt_q[3:0]*ELEM_W +: ELEM_W] = in_data;
            end else begin
              a_d[load_cnt_q[3:0]*ELEM_W +: ELEM_W] = in_data;
            end
            if (load_cnt_q == LOAD_LAST) begin
              load_cnt_d = '0;
              state_d    = ST_COMPUTE;
            end else begin
              load_cnt_d = load_cnt_q + 5'd1;
            end
          end
        end
        ST_COMPUTE: begin
          if (comp_cnt_q == COMP_LAST) begin
            comp_cnt_d = '0;
            c_d        = c_mat;
            state_d    = ST_DRAIN;
          end else begin
            comp_cnt_d = comp_cnt_q + 4'd1;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (drain_cnt_q == ELEM_LAST) begin
              drain_cnt_d = '0;
              done_d      = 1'b1;
              state_d     = ST_LOAD;
            end else begin
              drain_cnt_d = drain_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_core_controller.sv
// tb_tensor_core_controller
// Drives two controller instances (COMPUTE_CYCLES = 1 and 3) from one set of
// stimulus signals; sel3 chooses which instance is active and which one's
// outputs are observed. Results are checked against a matrix-product model.
module tb_tensor_core_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b0;
  logic       sel3 = 1'b0;

  logic       in_ready1, out_valid1, busy1, done1;
  logic [7:0] out_data1;
  logic       in_ready3, out_valid3, busy3, done3;
  logic [7:0] out_data3;

  logic       in_ready_v, out_valid_v, busy_v, done_v;
  logic [7:0] out_data_v;

  int         vectors = 0;
  int         miscompares = 0;
  int         op_a[16];
  int         op_b[16];
  logic [7:0] exp_c[16];

  always #5 clk = ~clk;

  tensor_core_controller dut1 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid & ~sel3),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .out_valid (out_valid1),
    .out_ready (out_ready & ~sel3),
    .out_data  (out_data1),
    .busy      (busy1),
    .done      (done1)
  );

  tensor_core_controller #(.COMPUTE_CYCLES(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid & sel3),
    .in_ready  (in_ready3),
    .in_data   (in_data),
    .out_valid (out_valid3),
    .out_ready (out_ready & sel3),
    .out_data  (out_data3),
    .busy      (busy3),
    .done      (done3)
  );

  assign in_ready_v  = sel3 ? in_ready3  : in_ready1;
  assign out_valid_v = sel3 ? out_valid3 : out_valid1;
  assign busy_v      = sel3 ? busy3      : busy1;
  assign done_v      = sel3 ? done3      : done1;
  assign out_data_v  = sel3 ? out_data3  : out_data1;

  // Reference: plain integer matrix product reduced mod 256.
  function automatic void build_model();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int s = 0;
        for (int k = 0; k < 4; k++) s += op_a[i*4+k] * op_b[k*4+j];
        exp_c[i*4+j] = 8'(s % 256);
      end
    end
  endfunction

  function automatic void fill_random();
    for (int i = 0; i < 16; i++) begin
      op_a[i] = int'($urandom_range(0, 255));
      op_b[i] = int'($urandom_range(0, 255));
    end
    build_model();
  endfunction

  task automatic send_operands(input int n_bytes, input bit gaps);
    int idx = 0;
    int guard = 0;
    bit hs;
    while (idx < n_bytes && guard < 1000) begin
      @(negedge clk);
      guard++;
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = (idx < 16) ? 8'(op_a[idx]) : 8'(op_b[idx-16]);
      hs = in_valid && in_ready_v;
      @(posedge clk);
      if (hs) idx++;
    end
    vectors++;
    if (idx < n_bytes) begin
      miscompares++;
      $display("[TB] FAIL load_timeout: accepted %0d bytes, required %0d", idx, n_bytes);
    end
  endtask

  task automatic receive_result(input int n_bytes, input bit stall, input int latency, input string name);
    int idx = 0;
    int k = 0;
    int first = -1;
    bit stalled = 1'b0;
    logic [7:0] held = 8'd0;
    while (idx < n_bytes && k < 2000) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      vectors++;
      if (busy_v !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL %s_busy: got %b at cycle %0d, required 1", name, busy_v, k);
      end
      vectors++;
      if (done_v !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL %s_done_early: got %b at cycle %0d, required 0", name, done_v, k);
      end
      if (out_valid_v === 1'b1 && first < 0) begin
        first = k;
        vectors++;
        if (k != latency) begin
          miscompares++;
          $display("[TB] FAIL %s_latency: out_valid after %0d edges, required %0d", name, k, latency);
        end
      end
      if (stalled) begin
        vectors++;
        if (out_valid_v !== 1'b1 || out_data_v !== held) begin
          miscompares++;
          $display("[TB] FAIL %s_stall_hold: valid %b data %0d, required valid 1 data %0d",
                   name, out_valid_v, out_data_v, held);
        end
      end
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 1'b0;
      if (out_valid_v === 1'b1) begin
        vectors++;
        if (out_data_v !== exp_c[idx]) begin
          miscompares++;
          $display("[TB] FAIL %s_data[%0d]: got %0d, required %0d", name, idx, out_data_v, exp_c[idx]);
        end
        held = out_data_v;
        if (out_ready) idx++;
        else stalled = 1'b1;
      end
      k++;
    end
    vectors++;
    if (idx < n_bytes) begin
      miscompares++;
      $display("[TB] FAIL %s_drain_timeout: received %0d bytes, required %0d", name, idx, n_bytes);
    end
    if (n_bytes == 16) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      vectors++;
      if (done_v !== 1'b1 || out_valid_v !== 1'b0 || in_ready_v !== 1'b1 || busy_v !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL %s_finish: done %b valid %b ready %b busy %b, required 1 0 1 0",
                 name, done_v, out_valid_v, in_ready_v, busy_v);
      end
      @(negedge clk);
      vectors++;
      if (done_v !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL %s_done_pulse: got %b one cycle later, required 0", name, done_v);
      end
    end
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid_v !== 1'b0 || busy_v !== 1'b0 || done_v !== 1'b0 || out_data_v !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: valid %b busy %b done %b data %0d, required 0 0 0 0",
               out_valid_v, busy_v, done_v, out_data_v);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready_v !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready_v);
    end
  endtask

  task automatic test_identity();
    for (int i = 0; i < 16; i++) begin
      op_a[i] = (i / 4 == i % 4) ? 1 : 0;
      op_b[i] = i + 1;
    end
    build_model();
    send_operands(32, 1'b0);
    receive_result(16, 1'b0, 1, "identity");
  endtask

  task automatic test_all_nines();
    for (int i = 0; i < 16; i++) begin
      op_a[i] = 9;
      op_b[i] = 9;
    end
    build_model();
    send_operands(32, 1'b1);
    receive_result(16, 1'b0, 1, "nines");
  endtask

  task automatic test_random_stall();
    for (int t = 0; t < 3; t++) begin
      fill_random();
      send_operands(32, 1'b1);
      receive_result(16, 1'b1, 1, "stall");
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 2; t++) begin
      fill_random();
      send_operands(32, 1'b0);
      receive_result(16, 1'b0, 1, "b2b");
    end
  endtask

  task automatic test_reset_mid_load();
    fill_random();
    send_operands(10, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    test_reset();
    for (int i = 0; i < 16; i++) begin
      op_a[i] = (i / 4 == i % 4) ? 1 : 0;
      op_b[i] = (i / 4 == i % 4) ? 2 : 0;
    end
    build_model();
    send_operands(32, 1'b0);
    receive_result(16, 1'b0, 1, "rst_mid_load");
  endtask

  task automatic test_clear_drain();
    fill_random();
    send_operands(32, 1'b0);
    receive_result(4, 1'b0, 1, "clear_pre");
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clear     = 1'b1;
    vectors++;
    if (out_valid_v !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clear_in_drain: out_valid %b on 5th drain cycle, required 1", out_valid_v);
    end
    @(negedge clk);
    clear     = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (out_valid_v !== 1'b0 || in_ready_v !== 1'b1 || done_v !== 1'b0 || busy_v !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clear_effect: valid %b ready %b done %b busy %b, required 0 1 0 0",
               out_valid_v, in_ready_v, done_v, busy_v);
    end
    @(negedge clk);
    vectors++;
    if (done_v !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clear_no_done: got %b, required 0", done_v);
    end
    fill_random();
    send_operands(32, 1'b1);
    receive_result(16, 1'b1, 1, "clear_post");
  endtask

  task automatic test_compute_cycles3();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel3      = 1'b1;
    for (int t = 0; t < 2; t++) begin
      fill_random();
      send_operands(32, 1'b1);
      receive_result(16, 1'b1, 3, "cc3");
    end
    sel3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_all_nines();
    test_random_stall();
    test_back_to_back();
    test_reset_mid_load();
    test_clear_drain();
    test_compute_cycles3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
